// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler: round-robin packet mover between bus terminal FIFOs.
// Each transfer arbitrates (IDLE), reads the winner's FIFO head (POP), and
// delivers it to its destination terminal(s) (PUSH): one packet per 3 cycles.
// Optional feature macro: BUS_BCAST_EN. When defined, destination == broadcast
// goes to every terminal except the sender. When undefined, it is dropped.
// Strobe semantics: pop[i] is a one-cycle read strobe, meaning "head word of
// FIFO i is consumed this cycle". It is only raised while pndng[i] is high in
// that same cycle. push[i] is a one-cycle write strobe, meaning "D_push is
// valid for terminal i this cycle". There is no back-pressure on push.
module bus_rr_scheduler #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [3:0]                 grant_id,
  output logic                       busy,
  output logic [15:0]                drop_cnt,
  output logic [1:0]                 o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ID = 4'(drvrs - 1);

  state_t               r_state;
  logic [3:0]           r_grant;
  logic [pckg_sz-1:0]   r_pkt;
  logic [drvrs-1:0]     r_push;
  logic                 r_drop;
  logic [15:0]          r_drop_cnt;

  logic                 w_any;
  logic [3:0]           w_sel;
  logic [pckg_sz-1:0]   w_head;
  logic                 w_pnd_g;
  logic [7:0]           w_dest;
  logic [drvrs-1:0]     w_push_vec;
  logic                 w_drop;
  logic [drvrs-1:0]     w_pop;

  // Round-robin pick: nearest requester after the last grant. k descends so
  // the smallest distance is the final assignment. grant+k < 2*drvrs always.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_grant;
    for (int k = drvrs; k >= 1; k--) begin
      for (int i = 0; i < drvrs; i++) begin
        if (pndng[i] && ((int'(r_grant) + k == i) || (int'(r_grant) + k == i + drvrs))) begin
          w_any = 1'b1;
          w_sel = 4'(i);
        end
      end
    end
  end

  // Mux the granted terminal's FIFO head and its pending flag.
  always_comb begin
    w_head  = '0;
    w_pnd_g = 1'b0;
    for (int i = 0; i < drvrs; i++) begin
      if (r_grant == 4'(i)) begin
        w_head  = D_pop[i*pckg_sz +: pckg_sz];
        w_pnd_g = pndng[i];
      end
    end
  end

  assign w_dest = w_head[pckg_sz-1 -: 8];

  // Destination decode. A packet with an empty delivery set is a drop.
  // This covers self-addressed, out-of-range, and disabled broadcast.
  always_comb begin
    w_push_vec = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (w_dest == 8'(i) && r_grant != 4'(i)) w_push_vec[i] = 1'b1;
    end
`ifdef BUS_BCAST_EN
    if (w_dest == broadcast) begin
      for (int i = 0; i < drvrs; i++) begin
        w_push_vec[i] = (r_grant != 4'(i));
      end
    end
`else
    if (w_dest == broadcast) w_push_vec = '0;
`endif
    w_drop = (w_push_vec == '0);
  end

  // Pop is combinational on the live pndng so a flag that fell after
  // arbitration suppresses the read.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < drvrs; i++) begin
      w_pop[i] = (r_state == S_POP) && w_pnd_g && (r_grant == 4'(i));
    end
  end

  // Transfer FSM: arbitrate, capture the head word, deliver or count a drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant    <= LAST_ID;
      r_pkt      <= '0;
      r_push     <= '0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_push <= '0;
          if (w_any) begin
            r_grant <= w_sel;
            r_state <= S_POP;
          end
        end
        S_POP: begin
          if (w_pnd_g) begin
            r_pkt   <= w_head;
            r_push  <= w_push_vec;
            r_drop  <= w_drop;
            r_state <= S_PUSH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PUSH: begin
          r_push <= '0;
          r_drop <= 1'b0;
          if (r_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pop         = w_pop;
  assign push        = r_push;
  assign D_push      = r_pkt;
  assign grant_id    = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign drop_cnt    = r_drop_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// tb_bus_rr_scheduler: directed scenarios plus randomized traffic against a
// timeline model of the round-robin scheduler. Honours BUS_BCAST_EN.
module tb_bus_rr_scheduler;

  localparam int N = 4;
  localparam int W = 32;
`ifdef BUS_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0]   pop, push;
  logic [W-1:0]   D_push;
  logic [3:0]     grant_id;
  logic           busy;
  logic [15:0]    drop_cnt;
  logic [1:0]     dbg_state;

  bus_rr_scheduler #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .grant_id(grant_id),
    .busy(busy), .drop_cnt(drop_cnt), .o_dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: a schedule of expected events in cycle numbers.
  int             m_grant, m_drop, m_pop_c, m_push_c;
  logic [W-1:0]   m_pkt;
  logic [N-1:0]   m_push_vec;
  bit             m_drop_pend;
  logic [N-1:0]   ob_pop, ob_push;
  logic           ob_busy;
  logic [3:0]     ob_grant;
  logic [W-1:0]   ob_dpush;
  logic [15:0]    ob_drop;
  logic [W-1:0]   exp_q[$];

  function automatic logic [N-1:0] route(input int src, input logic [7:0] dest, output bit drop);
    logic [N-1:0] r;
    r = '0;
    if (BCAST && dest == 8'hFF) begin
      r = '1;
      r[src] = 1'b0;
    end else if (int'(dest) < N && int'(dest) != src) begin
      r[int'(dest)] = 1'b1;
    end
    drop = (r == '0);
    return r;
  endfunction

  function automatic logic [N*W-1:0] mk_dp(input logic [W-1:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic model_reset();
    m_grant = N - 1; m_drop = 0; m_pkt = '0; m_pop_c = -1; m_push_c = -1;
    m_push_vec = '0; m_drop_pend = 1'b0; cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; pndng = '0; D_pop = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant_id), 32'(N - 1));
    check("rst_busy", 32'(busy), 32'(0));
    reset = 1'b1;
    model_reset();
  endtask

  // Driver + scoreboard for one clock cycle. Inputs are applied just after the
  // rising edge, outputs are compared on the falling edge, and the model
  // advances after the next rising edge.
  task automatic step(input logic [N-1:0] pn, input logic [N*W-1:0] dp);
    logic [N-1:0] e_pop, e_push, n_push_vec;
    bit           e_busy, found, n_drop_pend, rdrop;
    int           n_grant, n_pop_c, n_push_c, t;
    logic [W-1:0] n_pkt;
    pndng = pn;
    D_pop = dp;
    @(negedge clk);
    ob_pop = pop; ob_push = push; ob_busy = busy; ob_grant = grant_id;
    ob_dpush = D_push; ob_drop = drop_cnt;
    e_pop = '0; e_push = '0; e_busy = 1'b0; found = 1'b0; rdrop = 1'b0;
    n_grant = m_grant; n_pop_c = m_pop_c; n_push_c = m_push_c;
    n_push_vec = m_push_vec; n_drop_pend = m_drop_pend; n_pkt = m_pkt;
    if (cyc == m_pop_c) begin
      e_busy = 1'b1;
      if (pn[m_grant]) begin
        e_pop[m_grant] = 1'b1;
        n_pkt = dp[m_grant*W +: W];
        n_push_vec = route(m_grant, n_pkt[W-1 -: 8], rdrop);
        n_drop_pend = rdrop;
        n_push_c = cyc + 1;
      end
    end else if (cyc == m_push_c) begin
      e_busy = 1'b1;
      e_push = m_push_vec;
    end else if (pn != '0) begin
      for (int k = 1; k <= N; k++) begin
        t = (m_grant + k) % N;
        if (pn[t] && !found) begin
          found = 1'b1;
          n_grant = t;
          n_pop_c = cyc + 1;
        end
      end
    end
    check("pop", 32'(ob_pop), 32'(e_pop));
    check("push", 32'(ob_push), 32'(e_push));
    check("busy", 32'(ob_busy), 32'(e_busy));
    check("grant_id", 32'(ob_grant), 32'(m_grant));
    check("D_push", ob_dpush, m_pkt);
    check("drop_cnt", 32'(ob_drop), 32'(m_drop));
    check("pop_onehot0", 32'($onehot0(ob_pop)), 32'(1));
    check("pop_push_excl", 32'((ob_pop != '0) && (ob_push != '0)), 32'(0));
    @(posedge clk);
    #1;
    if (cyc == m_push_c && m_drop_pend && m_drop < 65535) m_drop++;
    m_grant = n_grant; m_pop_c = n_pop_c; m_push_c = n_push_c;
    m_push_vec = n_push_vec; m_drop_pend = n_drop_pend; m_pkt = n_pkt;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*W-1:0] dp;
    logic [N-1:0]   pn;
    logic [W-1:0]   pk;
    logic [7:0]     dest;

    // Single transfer from terminal 0 to terminal 2.
    do_reset();
    dp = mk_dp(32'h02AB_CDEF, '0, '0, '0);
    step(4'b0001, dp);
    step(4'b0001, dp);
    check("s1_pop_c1", 32'(ob_pop), 32'h1);
    step(4'b0000, dp);
    check("s1_push_c2", 32'(ob_push), 32'h4);
    check("s1_dpush_c2", ob_dpush, 32'h02AB_CDEF);
    step(4'b0000, dp);
    check("s1_busy_c3", 32'(ob_busy), 32'h0);

    // All terminals requesting: grants rotate 0,1,2,3,0.
    do_reset();
    dp = mk_dp(32'h0100_0000, 32'h0200_0001, 32'h0300_0002, 32'h0000_0003);
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    for (int s = 0; s < 15; s++) begin
      step(4'b1111, dp);
      if (s % 3 == 1) check("rr_order", 32'(ob_grant), exp_q.pop_front());
    end

    // Broadcast from terminal 1.
    do_reset();
    dp = mk_dp('0, 32'hFF00_0001, '0, '0);
    step(4'b0010, dp);
    step(4'b0010, dp);
    step(4'b0000, dp);
    check("bcast_push", 32'(ob_push), BCAST ? 32'hD : 32'h0);
    step(4'b0000, dp);
    check("bcast_drop", 32'(ob_drop), BCAST ? 32'd0 : 32'd1);

    // Self-addressed then out-of-range from terminal 2.
    do_reset();
    step(4'b0100, mk_dp('0, '0, 32'h0200_0000, '0));
    step(4'b0100, mk_dp('0, '0, 32'h0200_0000, '0));
    step(4'b0000, '0);
    check("self_push", 32'(ob_push), 32'h0);
    step(4'b0100, mk_dp('0, '0, 32'h0700_0000, '0));
    check("self_drop", 32'(ob_drop), 32'd1);
    step(4'b0100, mk_dp('0, '0, 32'h0700_0000, '0));
    step(4'b0000, '0);
    check("oor_push", 32'(ob_push), 32'h0);
    step(4'b0000, '0);
    check("oor_drop", 32'(ob_drop), 32'd2);

    // Request withdrawn in the POP cycle.
    do_reset();
    step(4'b1000, mk_dp('0, '0, '0, 32'h0100_0000));
    step(4'b0000, mk_dp('0, '0, '0, 32'h0100_0000));
    check("wd_pop", 32'(ob_pop), 32'h0);
    step(4'b0000, '0);
    check("wd_busy", 32'(ob_busy), 32'h0);
    check("wd_push", 32'(ob_push), 32'h0);
    check("wd_drop", 32'(ob_drop), 32'h0);

    // Reset asserted during PUSH.
    do_reset();
    dp = mk_dp(32'h0100_00AA, '0, '0, '0);
    step(4'b0001, dp);
    step(4'b0001, dp);
    check("rp_push_before", 32'(push), 32'h2);
    reset = 1'b0;
    #1;
    check("rp_push_async", 32'(push), 32'h0);
    check("rp_busy_async", 32'(busy), 32'h0);
    check("rp_dpush_async", D_push, 32'h0);
    check("rp_grant_async", 32'(grant_id), 32'(N - 1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    dp = mk_dp(32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    step(4'b1111, dp);
    step(4'b1111, dp);
    check("rp_first_grant", 32'(ob_grant), 32'h0);
    step(4'b0000, dp);

    // Randomized traffic.
    do_reset();
    for (int s = 0; s < 600; s++) begin
      pn = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: dest = 8'($urandom_range(0, N - 1));
          6:                dest = 8'hFF;
          default:          dest = 8'($urandom_range(N, 254));
        endcase
        pk = {dest, 24'($urandom)};
        dp[i*W +: W] = pk;
      end
      step(pn, dp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
